exmem_mem_sequencer: RTL
========================

Name: exmem_mem_sequencer

Overview:
- Controls the memory access of the instruction held in the EX/MEM pipeline buffer.
- Decodes that buffer's control word and runs a req/ack handshake with data memory, one access at a time.
- Stalls the upstream pipeline, including the EX/MEM buffer hold, until the access completes.
- Presents load data and a write-back strobe to the MEM/WB side, and flags memory timeouts.

Parameters:
S, 15, MSB index of datapath words (16-bit words)
TMO, 15, max WAIT cycles before timeout (1..2^TW-1)
TW, 4, width of timeout counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
CtrlIn  in  S+1  EX/MEM control word: [0]=mem_read, [1]=mem_write, [2]=byte_sel, [3]=reg_write; other bits ignored
AddrIn  in  S+1  effective address (EX/MEM lower result)
WordIn  in  S+1  store word data
ByteIn  in  8  store byte data
MemAck  in  1  memory completion strobe
MemRData  in  S+1  memory read data, valid with MemAck
MemReq  out  1  access request
MemRe  out  1  read qualifier
MemWe  out  1  write qualifier
MemByte  out  1  byte-access qualifier
MemAddr  out  S+1  latched address
MemWData  out  S+1  latched store data
Stall  out  1  hold upstream stages and EX/MEM buffer
LoadData  out  S+1  load result
WbValid  out  1  one-cycle load write-back strobe
Err  out  1  sticky timeout flag

Behaviour:

Reset (rst low, asynchronous):
- State is IDLE.
- Every registered output is 0: MemReq, MemRe, MemWe, MemByte, MemAddr, MemWData, LoadData, WbValid, Err.
- The timeout counter is 0.
- Stall is 0.
- Reset during WAIT abandons the access immediately; MemReq drops asynchronously.

Operation decode:
- memop = CtrlIn[0] | CtrlIn[1].
- Read and write both set: treat as a write; the read is ignored.

States: IDLE, WAIT, DONE, ERR.

IDLE:
- Stall = memop, combinationally.
- If memop at a clock edge, latch the following, clear the counter, and go to WAIT:
  - MemAddr = AddrIn.
  - MemWData = byte_sel ? {8'h00, ByteIn} : WordIn.
  - MemWe = mem_write; MemRe = mem_read & ~mem_write; MemByte = byte_sel.
  - reg_write into an internal register.
- MemAck is ignored in IDLE.

WAIT:
- MemReq = 1; Stall = 1.
- MemAck is sampled only in WAIT.
- On MemAck = 1 at an edge:
  - If the access is a read: LoadData = byte_sel ? {8'h00, MemRData[7:0]} : MemRData.
  - Go to DONE.
- Otherwise the counter increments. On the edge where the counter equals TMO-1 and MemAck = 0: go to ERR and set Err.

DONE (one cycle):
- MemReq = 0; Stall = 0, so the EX/MEM buffer advances at this edge.
- WbValid = 1 if the access was a read and reg_write was latched.
- CtrlIn is ignored in DONE (it still shows the completed op).
- Next state is IDLE.

ERR (one cycle):
- MemReq = 0; Stall = 0; WbValid = 0; LoadData unchanged.
- Next state is IDLE.
- Err stays 1 until reset.

Latency:
- Op present at IDLE cycle t gives MemReq high from t+1.
- Ack sampled at edge ending cycle t+k gives DONE at t+k+1 and IDLE at t+k+2.
- Stall is high for cycles t..t+k; minimum is 2 cycles (ack at t+1).

Boundaries:
- MemAck held high across DONE/IDLE is ignored.
- Back-to-back ops: the second op is seen in IDLE at t+k+2.
- Timeout occurs after exactly TMO WAIT cycles.
- LoadData holds its last value until the next read completes.
- Stores never update LoadData or assert WbValid.

Test Plan:
1. Reset held low, then released with CtrlIn=0 -> all outputs 0, state IDLE, Stall=0 for 5 cycles.
2. Word load: CtrlIn=16'h0009, AddrIn=16'h0040, ack after 3 WAIT cycles with MemRData=16'hBEEF -> MemReq/MemRe=1 for 3 cycles, MemAddr=0040; DONE: LoadData=BEEF, WbValid=1 one cycle; Stall=1 for 4 cycles.
3. Byte store: CtrlIn=16'h0006, ByteIn=8'hA5, WordIn=16'h1234, immediate ack -> MemWe=1, MemByte=1, MemWData=16'h00A5; WbValid stays 0; Stall high exactly 2 cycles.
4. Byte load of MemRData=16'h7F80 with CtrlIn=16'h000D -> LoadData=16'h0080, WbValid=1.
5. No ack, TMO=15 -> after 15 WAIT cycles: ERR, MemReq drops, Err=1 sticky; next load completes normally with Err still 1.
6. Reset asserted mid-WAIT (cycle 2) -> MemReq and Stall drop asynchronously, outputs cleared; late MemAck after release is ignored.

Source files
------------

// File: rtl/exmem_mem_sequencer_if.sv
// Bus between the EX/MEM pipeline buffer, the memory sequencer and data memory.
// The slave modport is the sequencer's view; the master modport drives the
// buffer/memory side (used by the environment around the sequencer).
interface exmem_mem_sequencer_if #(
    parameter int S = 15
);
    // EX/MEM buffer side
    logic [S:0] CtrlIn;
    logic [S:0] AddrIn;
    logic [S:0] WordIn;
    logic [7:0] ByteIn;
    // memory response
    logic       MemAck;
    logic [S:0] MemRData;
    // memory request
    logic       MemReq;
    logic       MemRe;
    logic       MemWe;
    logic       MemByte;
    logic [S:0] MemAddr;
    logic [S:0] MemWData;
    // pipeline / write-back side
    logic       Stall;
    logic [S:0] LoadData;
    logic       WbValid;
    logic       Err;

    modport slave (
        input  CtrlIn, AddrIn, WordIn, ByteIn, MemAck, MemRData,
        output MemReq, MemRe, MemWe, MemByte, MemAddr, MemWData,
        output Stall, LoadData, WbValid, Err
    );

    modport master (
        output CtrlIn, AddrIn, WordIn, ByteIn, MemAck, MemRData,
        input  MemReq, MemRe, MemWe, MemByte, MemAddr, MemWData,
        input  Stall, LoadData, WbValid, Err
    );
endinterface

// File: rtl/exmem_mem_sequencer.sv
// Memory-access sequencer for the instruction in the EX/MEM buffer.
// Decodes the control word, runs one req/ack access at a time against data
// memory, stalls the upstream pipeline while the access is outstanding,
// returns load data with a one-cycle write-back strobe and flags timeouts.
module exmem_mem_sequencer #(
    parameter int S   = 15,
    parameter int TMO = 15,
    parameter int TW  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    exmem_mem_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Last counter value allowed in WAIT before giving up.
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    // Zero-extend a byte to a datapath word.
    function automatic logic [S:0] zext_byte(input logic [7:0] b);
        return {{(S-7){1'b0}}, b};
    endfunction

    state_t        r_state;
    state_t        w_next;
    logic          w_memop;
    logic          w_ack;
    logic          w_tmo;
    logic          w_stall;

    logic          r_req;
    logic          r_re;
    logic          r_we;
    logic          r_byte;
    logic          r_regw;
    logic [S:0]    r_addr;
    logic [S:0]    r_wdata;
    logic [S:0]    r_ldata;
    logic          r_wbv;
    logic          r_err;
    logic [TW-1:0] r_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operation decode, next-state logic and the combinational stall.
    always_comb begin
        w_next  = r_state;
        w_memop = bus.CtrlIn[0] | bus.CtrlIn[1];
        w_ack   = 1'b0;
        w_tmo   = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Stall is gated by reset so it falls with an abandoned access.
                w_stall = w_memop & rst;
                if (w_memop) begin
                    w_next = ST_WAIT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                w_stall = rst;
                w_ack   = bus.MemAck;
                w_tmo   = ~bus.MemAck & (r_cnt == TMO_LAST);
                if (w_ack) begin
                    w_next = ST_DONE;
                end else if (w_tmo) begin
                    w_next = ST_ERR;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            ST_ERR: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request/qualifier latching, timeout counting and load/write-back results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req   <= 1'b0;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
            r_regw  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ldata <= '0;
            r_wbv   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_wbv <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_memop) begin
                        r_req   <= 1'b1;
                        r_addr  <= bus.AddrIn;
                        r_wdata <= bus.CtrlIn[2] ? zext_byte(bus.ByteIn) : bus.WordIn;
                        r_we    <= bus.CtrlIn[1];
                        // A combined read+write is executed as a plain write.
                        r_re    <= bus.CtrlIn[0] & ~bus.CtrlIn[1];
                        r_byte  <= bus.CtrlIn[2];
                        r_regw  <= bus.CtrlIn[3];
                        r_cnt   <= '0;
                    end else begin
                        r_req   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (w_ack) begin
                        r_req  <= 1'b0;
                        r_re   <= 1'b0;
                        r_we   <= 1'b0;
                        r_byte <= 1'b0;
                        if (r_re) begin
                            r_ldata <= r_byte ? zext_byte(bus.MemRData[7:0]) : bus.MemRData;
                            r_wbv   <= r_regw;
                        end else begin
                            r_ldata <= r_ldata;
                        end
                    end else if (w_tmo) begin
                        r_req  <= 1'b0;
                        r_re   <= 1'b0;
                        r_we   <= 1'b0;
                        r_byte <= 1'b0;
                        r_err  <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + TW'(1);
                    end
                end
                ST_DONE: begin
                    r_req <= 1'b0;
                end
                ST_ERR: begin
                    r_req <= 1'b0;
                end
                default: begin
                    r_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MemReq   = r_req;
    assign bus.MemRe    = r_re;
    assign bus.MemWe    = r_we;
    assign bus.MemByte  = r_byte;
    assign bus.MemAddr  = r_addr;
    assign bus.MemWData = r_wdata;
    assign bus.Stall    = w_stall;
    assign bus.LoadData = r_ldata;
    assign bus.WbValid  = r_wbv;
    assign bus.Err      = r_err;

endmodule
